// File: rtl/rf_alu_pkg.sv
// Shared widths and ALU opcode encodings for the register-file/ALU datapath slice.
package rf_alu_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_NAME_BITS  = 5;
  localparam int unsigned DEF_CTRL_BITS  = 4;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SGE = 4'b0101;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

endpackage

// File: rtl/reg_file_alu_alu_core.sv
// Combinational ALU: logic ops, add/sub with carry and signed-overflow flags, signed compares.
module alu_core
  import rf_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CTRL_BITS  = DEF_CTRL_BITS
) (
  input  logic [CTRL_BITS-1:0]  ctrl,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] c,
  output logic                  zero,
  output logic                  over,
  output logic                  c_out
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;

  // Subtraction as a + ~b + 1 so the top bit is the "no borrow" carry.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + {{DATA_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    c     = '0;
    over  = 1'b0;
    c_out = 1'b0;
    case (ctrl)
      OP_AND: c = a & b;
      OP_OR:  c = a | b;
      OP_NOR: c = ~(a | b);
      OP_ADD: begin
        c     = sum[DATA_WIDTH-1:0];
        c_out = sum[DATA_WIDTH];
        over  = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                (c[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      OP_SUB: begin
        c     = diff[DATA_WIDTH-1:0];
        c_out = diff[DATA_WIDTH];
        over  = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                (c[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      OP_SGE: c = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) >= $signed(b))};
      OP_SLT: c = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) <  $signed(b))};
      default: c = '0;
    endcase
    zero = (c == '0);
  end

endmodule

// File: rtl/reg_file_alu.sv
// Register file with r0 hardwired to zero, feeding alu_core; the ALU result is written back every clock.
module reg_file_alu
  import rf_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NAME_BITS  = DEF_NAME_BITS,
  parameter int unsigned CTRL_BITS  = DEF_CTRL_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NAME_BITS-1:0]  rs1,
  input  logic [NAME_BITS-1:0]  rs2,
  input  logic [NAME_BITS-1:0]  ws_in,
  input  logic [CTRL_BITS-1:0]  op_in,
  input  logic                  imm_e,
  input  logic [DATA_WIDTH-1:0] imm_d,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  zero,
  output logic                  over,
  output logic                  c_out
);

  logic [DATA_WIDTH-1:0] regs [2**NAME_BITS];
  logic [DATA_WIDTH-1:0] operand_b;

  // No write enable: the decoder selects r0 as destination for a no-op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '{default: '0};
    end else if (ws_in != '0) begin
      regs[ws_in] <= alu_result;
    end
  end

  assign rd1       = (!rst || rs1 == '0) ? '0 : regs[rs1];
  assign rd2       = (!rst || rs2 == '0) ? '0 : regs[rs2];
  assign operand_b = imm_e ? imm_d : rd2;

  alu_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .CTRL_BITS (CTRL_BITS)
  ) u_alu (
    .ctrl (op_in),
    .a    (rd1),
    .b    (operand_b),
    .c    (alu_result),
    .zero (zero),
    .over (over),
    .c_out(c_out)
  );

endmodule

// File: tb/tb_reg_file_alu.sv
// Self-checking bench for reg_file_alu: directed scenarios plus randomized instructions against a behavioural model.
module tb_reg_file_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, ws_in = '0;
  logic [3:0]  op_in = '0;
  logic        imm_e = 1'b0;
  logic [31:0] imm_d = '0;
  logic [31:0] rd1, rd2, alu_result;
  logic        zero, over, c_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] m [32];

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic        co;
  } exp_t;

  reg_file_alu #(.DATA_WIDTH(32), .NAME_BITS(5), .CTRL_BITS(4)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .ws_in(ws_in), .op_in(op_in),
    .imm_e(imm_e), .imm_d(imm_d), .rd1(rd1), .rd2(rd2), .alu_result(alu_result),
    .zero(zero), .over(over), .c_out(c_out)
  );

  always #5 clk = ~clk;

  function automatic exp_t golden(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    longint sa, sb, sres;
    longint unsigned ua, ub, ures;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    r  = '0;
    case (op)
      4'b0000: r.res = a & b;
      4'b0001: r.res = a | b;
      4'b1100: r.res = ~(a | b);
      4'b0010: begin
        ures  = ua + ub;
        r.res = ures[31:0];
        r.co  = (ures > 64'h0000_0000_FFFF_FFFF);
        sres  = sa + sb;
        r.ov  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      4'b0110: begin
        r.res = a - b;
        r.co  = (ua >= ub);
        sres  = sa - sb;
        r.ov  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      4'b0101: r.res = (sa >= sb) ? 32'd1 : 32'd0;
      4'b0111: r.res = (sa <  sb) ? 32'd1 : 32'd0;
      default: r.res = '0;
    endcase
    r.z = (r.res == 32'd0);
    return r;
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] addr);
    return (addr == 5'd0) ? 32'd0 : m[addr];
  endfunction

  function automatic exp_t model_now();
    logic [31:0] b;
    b = imm_e ? imm_d : mread(rs2);
    return golden(op_in, mread(rs1), b);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: cleared on reset, written from pre-edge inputs at each active edge.
  always @(negedge rst) foreach (m[i]) m[i] = '0;

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      e = model_now();
      if (ws_in != 5'd0) m[ws_in] = e.res;
    end
  end

  // Every-cycle comparison of all outputs, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    e = model_now();
    cmp("rd1",        rd1,            rst ? mread(rs1) : 32'd0);
    cmp("rd2",        rd2,            rst ? mread(rs2) : 32'd0);
    cmp("alu_result", alu_result,     e.res);
    cmp("zero",       32'(zero),      32'(e.z));
    cmp("over",       32'(over),      32'(e.ov));
    cmp("c_out",      32'(c_out),     32'(e.co));
  end

  // Apply an instruction just after an edge; it executes at the following edge.
  task automatic issue(input logic [4:0] ws, input logic [4:0] a, input logic [4:0] b,
                       input logic [3:0] op, input logic ie, input logic [31:0] imm);
    ws_in = ws; rs1 = a; rs2 = b; op_in = op; imm_e = ie; imm_d = imm;
    @(posedge clk); #1;
  endtask

  task automatic read_lit(input string name, input logic [4:0] addr, input logic [31:0] exp);
    ws_in = 5'd0; rs1 = addr; op_in = 4'b0000; imm_e = 1'b0;
    #1 cmp(name, rd1, exp);
  endtask

  localparam logic [3:0] OPS [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                     4'b0101, 4'b0111, 4'b1100, 4'b0011};

  initial begin
    exp_t g;
    // Hand-computed pins on the model itself.
    g = golden(4'b0010, 32'h7FFF_FFFF, 32'd1);
    cmp("model_add_ovf", {g.res[30:0], g.ov}, {31'h0, 1'b1});
    g = golden(4'b0110, 32'd3, 32'd5);
    cmp("model_sub_borrow", {g.res[3:0], 3'b0, g.co}, {4'hE, 3'b0, 1'b0});

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int unsigned k = 0; k < 8; k++)
      issue(5'(k + 1), 5'd0, 5'd0, 4'b0001, 1'b1, 32'hA5A5_0000 + k);

    // Scenario 1: asynchronous reset mid-cycle, then everything reads zero.
    #2 rst = 1'b0;
    #1 cmp("rst_async_rd", rd1, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    for (int unsigned k = 0; k < 32; k++) read_lit("reset_reg", 5'(k), 32'd0);
    issue(5'd0, 5'd0, 5'd0, 4'b0001, 1'b1, 32'd7);
    read_lit("r0_write", 5'd0, 32'd0);

    // Scenario 2: immediate and chained writes.
    issue(5'd1, 5'd0, 5'd0, 4'b0001, 1'b1, 32'd5);
    issue(5'd2, 5'd1, 5'd0, 4'b0001, 1'b0, 32'd0);
    issue(5'd6, 5'd1, 5'd0, 4'b0001, 1'b0, 32'd0);
    issue(5'd3, 5'd0, 5'd2, 4'b0010, 1'b0, 32'd0);
    issue(5'd7, 5'd6, 5'd6, 4'b0000, 1'b0, 32'd0);
    // Scenario 3: subtract and compares.
    issue(5'd4, 5'd0, 5'd3, 4'b0110, 1'b0, 32'd0);
    issue(5'd6, 5'd7, 5'd6, 4'b0101, 1'b0, 32'd0);
    issue(5'd5, 5'd0, 5'd2, 4'b0111, 1'b0, 32'd0);
    read_lit("s3_r1", 5'd1, 32'd5);
    read_lit("s3_r2", 5'd2, 32'd5);
    read_lit("s3_r3", 5'd3, 32'd5);
    read_lit("s3_r4", 5'd4, 32'hFFFF_FFFB);
    read_lit("s3_r5", 5'd5, 32'd1);
    read_lit("s3_r6", 5'd6, 32'd1);
    read_lit("s3_r7", 5'd7, 32'd5);

    // Scenario 4: signed compare corner (-1 vs 1).
    issue(5'd8,  5'd0, 5'd0, 4'b0001, 1'b1, 32'hFFFF_FFFF);
    issue(5'd9,  5'd0, 5'd0, 4'b0001, 1'b1, 32'd1);
    issue(5'd10, 5'd0, 5'd0, 4'b0001, 1'b1, 32'h7FFF_FFFF);
    ws_in = 5'd0; rs1 = 5'd8; rs2 = 5'd9; imm_e = 1'b0; op_in = 4'b0111;
    #1 cmp("slt_neg", alu_result, 32'd1);
    op_in = 4'b0101;
    #1 cmp("sge_neg", alu_result, 32'd0);

    // Scenario 5: flags.
    rs1 = 5'd10; imm_e = 1'b1; imm_d = 32'd1; op_in = 4'b0010;
    #1 cmp("add_ovf", {30'd0, over, c_out}, 32'b10);
    rs1 = 5'd8;
    #1 cmp("add_wrap", {alu_result[29:0], zero, c_out, over}, {30'd0, 3'b110});
    rs1 = 5'd1; imm_d = 32'd5; op_in = 4'b0110;
    #1 cmp("sub_eq", {30'd0, zero, c_out}, 32'b11);
    rs1 = 5'd0; rs2 = 5'd0; imm_e = 1'b0; op_in = 4'b1100;
    #1 cmp("nor_zero", alu_result, 32'hFFFF_FFFF);
    @(posedge clk); #1;

    // Scenario 6: read-during-write on r1 (holds 5).
    ws_in = 5'd1; rs1 = 5'd1; op_in = 4'b0010; imm_e = 1'b1; imm_d = 32'd1;
    #1 cmp("rdw_pre", rd1, 32'd5);
    @(posedge clk); #1;
    cmp("rdw_mid_rd1", rd1, 32'd6);
    cmp("rdw_mid_res", alu_result, 32'd7);
    @(posedge clk); #1;
    cmp("rdw_post", rd1, 32'd7);

    // Randomized instructions, with one asynchronous reset pulse in the middle.
    for (int unsigned n = 0; n < 2000; n++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 5))
        0: imm = 32'h7FFF_FFFF;
        1: imm = 32'h8000_0000;
        2: imm = 32'hFFFF_FFFF;
        3: imm = $urandom_range(0, 3);
        default: imm = $urandom;
      endcase
      if (n == 1000) begin
        #2 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
      end
      issue(($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            5'($urandom), 5'($urandom),
            ($urandom_range(0, 9) == 0) ? 4'($urandom) : OPS[$urandom_range(0, 7)],
            1'($urandom), imm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
